// File: rtl/sliding_window_buffer_if.sv
// sliding_window_buffer_if: pixel stream in, flattened KxK window and status out
interface sliding_window_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10,
    parameter int WIN = 3
) ();
    logic en;
    logic eol;
    logic eof;
    logic [DATA_WIDTH-1:0] data;
    logic [WIN*WIN*DATA_WIDTH-1:0] win;
    logic win_valid;
    logic [X_WIDTH-1:0] win_x;
    logic [Y_WIDTH-1:0] win_y;
    logic overrun;
    modport master (output en, eol, eof, data, input win, win_valid, win_x, win_y, overrun);
    modport slave (input en, eol, eof, data, output win, win_valid, win_x, win_y, overrun);
endinterface

// File: rtl/sliding_window_buffer.sv
// sliding_window_buffer: KxK sliding window over a raster pixel stream, two-stage pipeline
module sliding_window_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_WIDTH = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10,
    parameter int WIN = 3,
    parameter int BORDER_MODE = 0
) (
    input logic clk,
    input logic reset_n,
    sliding_window_buffer_if.slave s
);
    localparam int AW = $clog2(FRAME_WIDTH);
    localparam int DW = DATA_WIDTH;
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(FRAME_HEIGHT - 1);

    logic [X_WIDTH-1:0] nx, s1_x;
    logic [Y_WIDTH-1:0] ny, s1_y;
    logic drop_row, drop_frame, live, s1_valid, emit;
    logic [DW-1:0] s1_data;
    logic [DW-1:0] mem [WIN-1][FRAME_WIDTH];
    logic [DW-1:0] rd [WIN-1];
    logic [DW-1:0] col [WIN];
    logic [DW-1:0] wreg [WIN][WIN];
    logic [DW-1:0] wnext [WIN][WIN];
    logic [WIN*WIN*DW-1:0] win_nxt;

    assign live = s.en && !drop_row && !drop_frame;
    assign emit = BORDER_MODE != 0 || (int'(s1_x) >= WIN - 1 && int'(s1_y) >= WIN - 1);

    // Overflowing pixels are dropped but their row/frame markers still steer the position
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            nx <= '0;
            ny <= '0;
            drop_row <= 1'b0;
            drop_frame <= 1'b0;
            s.overrun <= 1'b0;
        end else if (s.en) begin
            if (s.eof) begin
                nx <= '0;
                ny <= '0;
                drop_row <= 1'b0;
                drop_frame <= 1'b0;
            end else if (s.eol) begin
                nx <= '0;
                drop_row <= 1'b0;
                if (ny == Y_LAST) begin
                    drop_frame <= 1'b1;
                    s.overrun <= 1'b1;
                end else
                    ny <= ny + 1'b1;
            end else if (nx == X_LAST) begin
                drop_row <= 1'b1;
                s.overrun <= 1'b1;
            end else
                nx <= nx + 1'b1;
        end

    // Chained line memories: old contents shift one row down as the new pixel lands
    always_ff @(posedge clk)
        if (live) begin
            mem[0][nx[AW-1:0]] <= s.data;
            for (int k = 1; k < WIN - 1; k++) mem[k][nx[AW-1:0]] <= mem[k-1][nx[AW-1:0]];
            for (int k = 0; k < WIN - 1; k++) rd[k] <= mem[k][nx[AW-1:0]];
            s1_x <= nx;
            s1_y <= ny;
            s1_data <= s.data;
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) s1_valid <= 1'b0;
        else s1_valid <= live;

    always_comb begin
        win_nxt = '0;
        col[WIN-1] = s1_data;
        for (int r = 0; r < WIN - 1; r++) col[r] = rd[WIN-2-r];
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) wnext[r][c] = wreg[r][c+1];
            wnext[r][WIN-1] = col[r];
        end
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                win_nxt[(r*WIN+c)*DW +: DW] = (BORDER_MODE != 0 &&
                    (int'(s1_x) < WIN - 1 - c || int'(s1_y) < WIN - 1 - r)) ? '0 : wnext[r][c];
    end

    always_ff @(posedge clk)
        if (s1_valid) wreg <= wnext;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s.win <= '0;
            s.win_valid <= 1'b0;
            s.win_x <= '0;
            s.win_y <= '0;
        end else begin
            s.win_valid <= s1_valid && emit;
            if (s1_valid && emit) begin
                s.win <= win_nxt;
                s.win_x <= s1_x;
                s.win_y <= s1_y;
            end
        end
endmodule

// File: tb/tb_sliding_window_buffer.sv
// tb_sliding_window_buffer: randomized bench checking windows against a frame-array model
module tb_sliding_window_buffer;
    typedef struct {
        int cyc;
        int x;
        int y;
        logic [249:0] w;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0, eol = 1'b0, eof = 1'b0;
    logic [7:0] data = '0;
    logic en5 = 1'b0, eol5 = 1'b0, eof5 = 1'b0;
    logic [9:0] data5 = '0;
    int cyc = 0;
    int vec = 0;
    int errs = 0;
    int img [2][16][16];
    ev_t q0[$], q1[$], q5[$], e0[$], e1[$], e5[$];

    sliding_window_buffer_if #(.DATA_WIDTH(8), .X_WIDTH(4), .Y_WIDTH(3), .WIN(3)) b0 ();
    sliding_window_buffer_if #(.DATA_WIDTH(8), .X_WIDTH(4), .Y_WIDTH(3), .WIN(3)) b1 ();
    sliding_window_buffer_if #(.DATA_WIDTH(10), .X_WIDTH(5), .Y_WIDTH(4), .WIN(5)) b5 ();

    assign b0.en = en;
    assign b0.eol = eol;
    assign b0.eof = eof;
    assign b0.data = data;
    assign b1.en = en;
    assign b1.eol = eol;
    assign b1.eof = eof;
    assign b1.data = data;
    assign b5.en = en5;
    assign b5.eol = eol5;
    assign b5.eof = eof5;
    assign b5.data = data5;

    sliding_window_buffer #(.DATA_WIDTH(8), .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .X_WIDTH(4),
        .Y_WIDTH(3), .WIN(3), .BORDER_MODE(0)) dut0 (.clk(clk), .reset_n(reset_n), .s(b0));
    sliding_window_buffer #(.DATA_WIDTH(8), .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .X_WIDTH(4),
        .Y_WIDTH(3), .WIN(3), .BORDER_MODE(1)) dut1 (.clk(clk), .reset_n(reset_n), .s(b1));
    sliding_window_buffer #(.DATA_WIDTH(10), .FRAME_WIDTH(16), .FRAME_HEIGHT(8), .X_WIDTH(5),
        .Y_WIDTH(4), .WIN(5), .BORDER_MODE(1)) dut5 (.clk(clk), .reset_n(reset_n), .s(b5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input int x, input int y, input logic [249:0] w);
        ev_t e;
        e.cyc = c;
        e.x = x;
        e.y = y;
        e.w = w;
        return e;
    endfunction

    always @(negedge clk) begin
        if (b0.win_valid) q0.push_back(mk(cyc, int'(b0.win_x), int'(b0.win_y), 250'(b0.win)));
        if (b1.win_valid) q1.push_back(mk(cyc, int'(b1.win_x), int'(b1.win_y), 250'(b1.win)));
        if (b5.win_valid) q5.push_back(mk(cyc, int'(b5.win_x), int'(b5.win_y), 250'(b5.win)));
    end

    // Window straight from the stored frame: taps above or left of the frame read as zero
    function automatic logic [249:0] model(input int s, input int k, input int dw, input int x, input int y);
        logic [249:0] w;
        w = '0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                if (x - (k - 1 - c) >= 0 && y - (k - 1 - r) >= 0)
                    w = w | (250'(img[s][y-(k-1-r)][x-(k-1-c)]) << ((r * k + c) * dw));
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); q5.delete();
        e0.delete(); e1.delete(); e5.delete();
    endtask

    task automatic put3(input int x, input int y, input int v, input bit l, input bit f, input bit live);
        en = 1'b1; eol = l; eof = f; data = 8'(v);
        if (live) begin
            img[0][y][x] = v;
            if (x >= 2 && y >= 2) e0.push_back(mk(cyc + 2, x, y, model(0, 3, 8, x, y)));
            e1.push_back(mk(cyc + 2, x, y, model(0, 3, 8, x, y)));
        end
        @(posedge clk);
        #1;
        en = 1'b0; eol = 1'b0; eof = 1'b0;
    endtask

    task automatic put5(input int x, input int y, input int v, input bit l, input bit f);
        en5 = 1'b1; eol5 = l; eof5 = f; data5 = 10'(v);
        img[1][y][x] = v;
        e5.push_back(mk(cyc + 2, x, y, model(1, 5, 10, x, y)));
        @(posedge clk);
        #1;
        en5 = 1'b0; eol5 = 1'b0; eof5 = 1'b0;
    endtask

    task automatic frame3(input bit gaps, input bit rnd);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) begin
                if (gaps) while ($urandom_range(0, 1) == 1) idle(1);
                put3(x, y, rnd ? int'($urandom_range(0, 255)) : 16 * y + x + 1, x == 7, x == 7 && y == 3, 1'b1);
            end
        idle(4);
    endtask

    task automatic test_reset();
        idle(3);
        vec++;
        if ({b0.win, b0.win_valid, b0.win_x, b0.win_y, b0.overrun} !== '0) begin
            errs++; $display("FAIL reset_b0 got valid=%b x=%0d y=%0d ovr=%b want all 0", b0.win_valid, b0.win_x, b0.win_y, b0.overrun);
        end
        vec++;
        if ({b1.win, b1.win_valid, b1.win_x, b1.win_y, b1.overrun} !== '0) begin
            errs++; $display("FAIL reset_b1 got valid=%b x=%0d y=%0d ovr=%b want all 0", b1.win_valid, b1.win_x, b1.win_y, b1.overrun);
        end
        vec++;
        if ({b5.win, b5.win_valid, b5.win_x, b5.win_y, b5.overrun} !== '0) begin
            errs++; $display("FAIL reset_b5 got valid=%b x=%0d y=%0d ovr=%b want all 0", b5.win_valid, b5.win_x, b5.win_y, b5.overrun);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_mode0_ramp();
        int t [9] = '{1, 2, 3, 17, 18, 19, 33, 34, 35};
        logic [249:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w = w | (250'(t[i]) << (8 * i));
        clear_q();
        frame3(1'b0, 1'b0);
        vec++;
        if (q0.size() != 12) begin errs++; $display("FAIL mode0_count got %0d want 12", q0.size()); end
        if (q0.size() > 0 && e0.size() > 0) begin
            vec++;
            if (q0[0].x != 2 || q0[0].y != 2 || q0[0].w !== w || q0[0].cyc != e0[0].cyc) begin
                errs++; $display("FAIL mode0_first got (%0d,%0d) cyc=%0d w=%h want (2,2) cyc=%0d w=%h", q0[0].x, q0[0].y, q0[0].cyc, q0[0].w, e0[0].cyc, w);
            end
        end
        for (int i = 0; i < q0.size() && i < e0.size(); i++) begin
            vec++;
            if (q0[i].x != e0[i].x || q0[i].y != e0[i].y || q0[i].cyc != e0[i].cyc || q0[i].w !== e0[i].w) begin
                errs++; $display("FAIL mode0_seq[%0d] got (%0d,%0d) cyc=%0d w=%h want (%0d,%0d) cyc=%0d w=%h", i, q0[i].x, q0[i].y, q0[i].cyc, q0[i].w, e0[i].x, e0[i].y, e0[i].cyc, e0[i].w);
            end
        end
    endtask

    task automatic test_mode1_ramp();
        int t [9] = '{0, 0, 0, 0, 1, 2, 0, 17, 18};
        logic [249:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w = w | (250'(t[i]) << (8 * i));
        clear_q();
        frame3(1'b0, 1'b0);
        vec++;
        if (q1.size() != 32) begin errs++; $display("FAIL mode1_count got %0d want 32", q1.size()); end
        if (q1.size() == 32) begin
            vec++;
            if (q1[0].x != 0 || q1[0].y != 0 || q1[0].w !== (250'(1) << 64)) begin
                errs++; $display("FAIL mode1_origin got (%0d,%0d) w=%h want (0,0) w=%h", q1[0].x, q1[0].y, q1[0].w, 250'(1) << 64);
            end
            vec++;
            if (q1[9].x != 1 || q1[9].y != 1 || q1[9].w !== w) begin
                errs++; $display("FAIL mode1_11 got (%0d,%0d) w=%h want (1,1) w=%h", q1[9].x, q1[9].y, q1[9].w, w);
            end
        end
        for (int i = 0; i < q1.size() && i < e1.size(); i++) begin
            vec++;
            if (q1[i].x != e1[i].x || q1[i].y != e1[i].y || q1[i].cyc != e1[i].cyc || q1[i].w !== e1[i].w) begin
                errs++; $display("FAIL mode1_seq[%0d] got (%0d,%0d) cyc=%0d w=%h want (%0d,%0d) cyc=%0d w=%h", i, q1[i].x, q1[i].y, q1[i].cyc, q1[i].w, e1[i].x, e1[i].y, e1[i].cyc, e1[i].w);
            end
        end
    endtask

    task automatic test_random_gaps(input bit rnd);
        clear_q();
        frame3(1'b1, rnd);
        vec++;
        if (q0.size() != 12 || q1.size() != 32) begin
            errs++; $display("FAIL gaps_count rnd=%0d got %0d/%0d want 12/32", rnd, q0.size(), q1.size());
        end
        for (int i = 0; i < q0.size() && i < e0.size(); i++) begin
            vec++;
            if (q0[i].x != e0[i].x || q0[i].y != e0[i].y || q0[i].cyc != e0[i].cyc || q0[i].w !== e0[i].w) begin
                errs++; $display("FAIL gaps0_seq[%0d] got (%0d,%0d) cyc=%0d w=%h want (%0d,%0d) cyc=%0d w=%h", i, q0[i].x, q0[i].y, q0[i].cyc, q0[i].w, e0[i].x, e0[i].y, e0[i].cyc, e0[i].w);
            end
        end
        for (int i = 0; i < q1.size() && i < e1.size(); i++) begin
            vec++;
            if (q1[i].x != e1[i].x || q1[i].y != e1[i].y || q1[i].cyc != e1[i].cyc || q1[i].w !== e1[i].w) begin
                errs++; $display("FAIL gaps1_seq[%0d] got (%0d,%0d) cyc=%0d w=%h want (%0d,%0d) cyc=%0d w=%h", i, q1[i].x, q1[i].y, q1[i].cyc, q1[i].w, e1[i].x, e1[i].y, e1[i].cyc, e1[i].w);
            end
        end
    endtask

    task automatic test_overrun();
        clear_q();
        for (int x = 0; x < 8; x++) put3(x, 0, x + 1, x == 7, 1'b0, 1'b1);
        vec++;
        if (b0.overrun !== 1'b0) begin errs++; $display("FAIL overrun_early got %b want 0", b0.overrun); end
        for (int x = 0; x < 9; x++) put3(x, 1, 16 + x + 1, x == 8, 1'b0, x < 8);
        vec++;
        if (b0.overrun !== 1'b1 || b1.overrun !== 1'b1) begin
            errs++; $display("FAIL overrun_set got %b/%b want 1/1", b0.overrun, b1.overrun);
        end
        for (int y = 2; y < 4; y++)
            for (int x = 0; x < 8; x++) put3(x, y, 16 * y + x + 1, x == 7, x == 7 && y == 3, 1'b1);
        idle(4);
        vec++;
        if (q0.size() != 12 || q1.size() != 32) begin
            errs++; $display("FAIL overrun_count got %0d/%0d want 12/32", q0.size(), q1.size());
        end
        for (int i = 0; i < q0.size() && i < e0.size(); i++) begin
            vec++;
            if (q0[i].x != e0[i].x || q0[i].y != e0[i].y || q0[i].cyc != e0[i].cyc || q0[i].w !== e0[i].w) begin
                errs++; $display("FAIL overrun0_seq[%0d] got (%0d,%0d) w=%h want (%0d,%0d) w=%h", i, q0[i].x, q0[i].y, q0[i].w, e0[i].x, e0[i].y, e0[i].w);
            end
        end
        for (int i = 0; i < q1.size() && i < e1.size(); i++) begin
            vec++;
            if (q1[i].x != e1[i].x || q1[i].y != e1[i].y || q1[i].cyc != e1[i].cyc || q1[i].w !== e1[i].w) begin
                errs++; $display("FAIL overrun1_seq[%0d] got (%0d,%0d) w=%h want (%0d,%0d) w=%h", i, q1[i].x, q1[i].y, q1[i].w, e1[i].x, e1[i].y, e1[i].w);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_q();
        for (int i = 0; i < 21; i++) put3(i % 8, i / 8, 16 * (i / 8) + i % 8 + 1, i % 8 == 7, 1'b0, 1'b1);
        en = 1'b1; data = 8'd38;
        #2;
        vec++;
        if (b0.win_valid !== 1'b1 || b0.win_x !== 4'd3) begin
            errs++; $display("FAIL midframe_busy got valid=%b x=%0d want 1 x=3", b0.win_valid, b0.win_x);
        end
        reset_n = 1'b0;
        #1;
        vec++;
        if ({b0.win, b0.win_valid, b0.win_x, b0.win_y, b0.overrun} !== '0) begin
            errs++; $display("FAIL midframe_clear_b0 got valid=%b x=%0d y=%0d ovr=%b want all 0", b0.win_valid, b0.win_x, b0.win_y, b0.overrun);
        end
        vec++;
        if ({b1.win, b1.win_valid, b1.win_x, b1.win_y, b1.overrun} !== '0) begin
            errs++; $display("FAIL midframe_clear_b1 got valid=%b x=%0d y=%0d ovr=%b want all 0", b1.win_valid, b1.win_x, b1.win_y, b1.overrun);
        end
        en = 1'b0;
        idle(2);
        clear_q();
        reset_n = 1'b1;
        idle(1);
        frame3(1'b0, 1'b1);
        vec++;
        if (q0.size() != 12) begin errs++; $display("FAIL midframe_count got %0d want 12", q0.size()); end
        for (int i = 0; i < q0.size() && i < e0.size(); i++) begin
            vec++;
            if (q0[i].x != e0[i].x || q0[i].y != e0[i].y || q0[i].cyc != e0[i].cyc || q0[i].w !== e0[i].w) begin
                errs++; $display("FAIL midframe_seq[%0d] got (%0d,%0d) w=%h want (%0d,%0d) w=%h", i, q0[i].x, q0[i].y, q0[i].w, e0[i].x, e0[i].y, e0[i].w);
            end
        end
    endtask

    task automatic test_win5();
        logic [249:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) w = w | (250'(16 * r + c + 1) << ((r * 5 + c) * 10));
        clear_q();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++) put5(x, y, 16 * y + x + 1, x == 15, x == 15 && y == 7);
        idle(4);
        vec++;
        if (q5.size() != 128) begin errs++; $display("FAIL win5_count got %0d want 128", q5.size()); end
        if (q5.size() == 128) begin
            vec++;
            if (q5[68].x != 4 || q5[68].y != 4 || q5[68].w !== w) begin
                errs++; $display("FAIL win5_44 got (%0d,%0d) w=%h want (4,4) w=%h", q5[68].x, q5[68].y, q5[68].w, w);
            end
        end
        for (int i = 0; i < q5.size() && i < e5.size(); i++) begin
            vec++;
            if (q5[i].x != e5[i].x || q5[i].y != e5[i].y || q5[i].cyc != e5[i].cyc || q5[i].w !== e5[i].w) begin
                errs++; $display("FAIL win5_seq[%0d] got (%0d,%0d) cyc=%0d w=%h want (%0d,%0d) cyc=%0d w=%h", i, q5[i].x, q5[i].y, q5[i].cyc, q5[i].w, e5[i].x, e5[i].y, e5[i].cyc, e5[i].w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_ramp();
        test_mode1_ramp();
        test_random_gaps(1'b0);
        test_random_gaps(1'b1);
        test_overrun();
        test_reset_mid_frame();
        test_win5();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/sliding_window_buffer.md
# sliding_window_buffer

Parametrised KxK sliding-window generator for the streaming pixel pipeline. It replaces hand-built 3x3 row buffers and per-row queues with one block, generic in pixel width, frame geometry and window size. It tracks pixel coordinates from end-of-row/end-of-frame markers and emits one window per accepted pixel. Two border modes are provided: suppress incomplete windows, or zero-pad them. Downstream kernels (Sobel, connected-components neighbourhoods) consume its flattened window output.

## Interface
- DATA_WIDTH, 8, bits per pixel
- FRAME_WIDTH, 640, maximum pixels per row
- FRAME_HEIGHT, 480, maximum rows per frame
- X_WIDTH, 10, coordinate width for x (>= clog2(FRAME_WIDTH))
- Y_WIDTH, 10, coordinate width for y (>= clog2(FRAME_HEIGHT))
- WIN, 3, window edge; odd, 3..7
- BORDER_MODE, 0, 0 = emit only fully in-frame windows; 1 = emit every window, out-of-frame taps forced to 0

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  pixel accept strobe
- eol  in  1  accepted pixel is last of its row (qualified by en)
- eof  in  1  accepted pixel is last of its frame (qualified by en; implies eol)
- data  in  DATA_WIDTH  pixel value
- win  out  WIN*WIN*DATA_WIDTH  flattened window; tap (r,c) at bits [((r*WIN+c)+1)*DATA_WIDTH-1 : (r*WIN+c)*DATA_WIDTH]
- win_valid  out  1  win/win_x/win_y valid this cycle
- win_x  out  X_WIDTH  x of bottom-right tap (the pixel that produced the window)
- win_y  out  Y_WIDTH  y of bottom-right tap
- overrun  out  1  sticky: geometry exceeded FRAME_WIDTH/FRAME_HEIGHT

## Operation
- Position registers (nx, ny) hold the coordinate of the next pixel; reset value (0,0).
- Accepted pixel (en=1) is at (nx, ny). Next position:
  - eof: (0,0)
  - eol only: (0, ny+1)
  - otherwise: (nx+1, ny)
- WIN-1 line memories, FRAME_WIDTH deep, addressed by x and chained. Memory k holds row y-1-k. Same-address access is read-before-write.
- Window register: WIN rows x WIN columns, shifted left on each accept. Row r = row y-(WIN-1-r), column c = x-(WIN-1-c); tap (WIN-1,WIN-1) = accepted pixel.
- BORDER_MODE 0: window emitted only if x >= WIN-1 and y >= WIN-1.
- BORDER_MODE 1: window emitted for every accepted pixel. Tap (r,c) is forced to 0 if x < WIN-1-c or y < WIN-1-r. This masks the wrap of the previous row's tail.
- Overrun handling:
  - An accept at nx = FRAME_WIDTH-1 without eol sets overrun. Further pixels are dropped (no memory write, no window) until an eol or eof accept; the eol/eof marker is still honoured.
  - An eol at ny = FRAME_HEIGHT-1 without eof sets overrun. All pixels are dropped until an eof accept.
  - overrun is cleared only by reset.
- Rows shorter than FRAME_WIDTH are legal. Taps beyond the previous row's length are undefined.
- Reset clears position, pipeline valids, all outputs and overrun; line memory contents are not cleared. Border rules guarantee stale contents never reach a valid window in mode 1, or in mode 0 after WIN-1 full rows.

## Timing
- Two-stage pipeline: synchronous line-memory read, then window register/mask. Pipeline advances every cycle; en qualifies input only.
- Latency: win_valid asserts exactly 2 cycles after the accepting cycle, for 1 cycle. Throughput is one window per cycle. en=0 cycles produce win_valid=0 two cycles later.
- Outputs are registered. Reset values: win=0, win_valid=0, win_x=0, win_y=0, overrun=0.
- overrun rises 1 cycle after the offending accept.
- Reset assertion clears outputs asynchronously, even mid-pipeline; in-flight windows are discarded.

## Test plan
- Mode 0, WIN=3, FRAME 8x4, pixel = 16*y+x+1, en=1 continuous:
  - Exactly 12 windows.
  - First window at win=(2,2), taps row-major {1,2,3,17,18,19,33,34,35}, 2 cycles after pixel (2,2) accepted.
- Mode 1, same stream:
  - 32 windows.
  - (0,0) window: all taps 0 except tap(2,2)=1.
  - (1,1) window: row0 zero; row1 {0,1,2}; row2 {0,17,18}.
- Mode 0 with pseudo-random en gaps (~50% duty):
  - Window sequence identical to the first scenario.
  - Each win_valid exactly 2 cycles after its accept.
- FRAME_WIDTH=8, row 1 sent with 9 pixels then eol:
  - overrun=1 one cycle after 9th accept.
  - 9th pixel produces no window.
  - Row 2 windows start at x=2.
- reset_n pulsed low at pixel (5,2):
  - All outputs 0 immediately.
  - Next frame in mode 0 yields first window (2,2) with correct taps and no stale data.
- WIN=5, DATA_WIDTH=10, mode 1, FRAME 16x8 ramp:
  - Window at (4,4) tap(r,c) = 16*r+c+1 at offset (r*5+c)*10.
